// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline hazard unit: forwarding selects,
// stall FSM states and the shadow-entry bundle tracked per stage.
package pipeline_pkg;

  localparam int DEST_W = 8;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam logic [DEST_W-1:0] REG_ZERO = '0;

  typedef enum logic {
    RUN,
    STALL
  } haz_state_e;

  typedef struct packed {
    logic              valid;
    logic [DEST_W-1:0] dest;
    logic              reg_write;
    logic              mem_read;
  } shadow_t;

endpackage

// File: rtl/pipeline_hazard_unit_match.sv
// hazard_match: does one ID source register depend on one shadow entry.
// Register zero is never a producer.
module hazard_match
  import pipeline_pkg::*;
(
  input  logic              id_valid,
  input  logic              uses,
  input  logic [DEST_W-1:0] src,
  input  shadow_t           entry,
  output logic              hit
);

  logic unused_ld;

  assign unused_ld = entry.mem_read;

  assign hit = id_valid & uses
             & entry.valid & entry.reg_write
             & (entry.dest == src)
             & (entry.dest != REG_ZERO);

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard/forwarding controller for the 5-stage pipeline.
// HAZ_PERF_CNT_EN adds saturating stall/flush event counters.
module pipeline_hazard_unit
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int LOAD_STALLS  = 1,
  parameter int BRANCH_STAGE = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_jump,
  input  logic                  branch_taken,
  output logic                  pc_hold,
  output logic                  if_id_hold,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic                  flush_ex_mem,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  wb_bypass_a,
  output logic                  wb_bypass_b
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]           stall_count,
  output logic [31:0]           flush_count
`endif
);

  shadow_t ex_q, mem_q, wb_q, id_e;

  haz_state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] fwd_a_q, fwd_b_q;
  logic [1:0] fwd_a_d, fwd_b_d;

  logic [DEST_W-1:0] rs_w, rt_w;
  logic ex_rs, ex_rt, mem_rs, mem_rt;
  logic wb_rs, wb_rt;
  logic load_use, stall_raw, stall;

  assign rs_w = DEST_W'(id_rs);
  assign rt_w = DEST_W'(id_rt);

  hazard_match u_ex_rs (
    .id_valid (id_valid),
    .uses     (id_uses_rs),
    .src      (rs_w),
    .entry    (ex_q),
    .hit      (ex_rs)
  );

  hazard_match u_ex_rt (
    .id_valid (id_valid),
    .uses     (id_uses_rt),
    .src      (rt_w),
    .entry    (ex_q),
    .hit      (ex_rt)
  );

  hazard_match u_mem_rs (
    .id_valid (id_valid),
    .uses     (id_uses_rs),
    .src      (rs_w),
    .entry    (mem_q),
    .hit      (mem_rs)
  );

  hazard_match u_mem_rt (
    .id_valid (id_valid),
    .uses     (id_uses_rt),
    .src      (rt_w),
    .entry    (mem_q),
    .hit      (mem_rt)
  );

  hazard_match u_wb_rs (
    .id_valid (id_valid),
    .uses     (id_uses_rs),
    .src      (rs_w),
    .entry    (wb_q),
    .hit      (wb_rs)
  );

  hazard_match u_wb_rt (
    .id_valid (id_valid),
    .uses     (id_uses_rt),
    .src      (rt_w),
    .entry    (wb_q),
    .hit      (wb_rt)
  );

  assign load_use = ex_q.mem_read & (ex_rs | ex_rt);

  // cnt_q holds the stall cycles still owed after the detect cycle
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_raw = 1'b0;
    unique case (state_q)
      RUN: begin
        if (load_use) begin
          stall_raw = 1'b1;
          if (LOAD_STALLS > 1) begin
            state_d = STALL;
            cnt_d   = 2'(LOAD_STALLS - 1);
          end
        end
      end
      STALL: begin
        stall_raw = 1'b1;
        cnt_d     = cnt_q - 2'd1;
        if (cnt_q == 2'd1) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    if (branch_taken) begin
      state_d = RUN;
      cnt_d   = '0;
    end
  end

  assign stall = stall_raw & ~branch_taken;

  assign pc_hold      = stall;
  assign if_id_hold   = stall;
  assign flush_if_id  = branch_taken
                      | (id_jump & id_valid & ~stall);
  assign flush_id_ex  = branch_taken | stall;
  assign flush_ex_mem = branch_taken
                      & (BRANCH_STAGE == 3);

  assign wb_bypass_a = wb_rs;
  assign wb_bypass_b = wb_rt;
  assign fwd_a       = fwd_a_q;
  assign fwd_b       = fwd_b_q;

  always_comb begin
    fwd_a_d = ex_rs  ? FWD_EXMEM
            : mem_rs ? FWD_MEMWB : FWD_REG;
    fwd_b_d = ex_rt  ? FWD_EXMEM
            : mem_rt ? FWD_MEMWB : FWD_REG;
  end

  always_comb begin
    id_e.valid     = id_valid & ~flush_id_ex;
    id_e.dest      = DEST_W'(id_dest);
    id_e.reg_write = id_reg_write;
    id_e.mem_read  = id_mem_read;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      state_q <= RUN;
      cnt_q   <= '0;
      fwd_a_q <= FWD_REG;
      fwd_b_q <= FWD_REG;
    end else begin
      ex_q    <= id_e;
      mem_q   <= flush_ex_mem ? '0 : ex_q;
      wb_q    <= mem_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // a killed ID slot enters EX as a bubble
      if (branch_taken) begin
        fwd_a_q <= FWD_REG;
        fwd_b_q <= FWD_REG;
      end else if (!stall) begin
        fwd_a_q <= fwd_a_d;
        fwd_b_q <= fwd_b_d;
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (pc_hold && (stall_count != '1))
        stall_count <= stall_count + 32'd1;
      if (flush_if_id && (flush_count != '1))
        flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Bench for pipeline_hazard_unit: directed table, corner sequences
// and random traffic against a stage-list reference model.
module tb_pipeline_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       id_uses_rs, id_uses_rt;
  logic       id_reg_write, id_mem_read;
  logic       id_jump, branch_taken;

  logic [1:0] pc_hold_o, if_id_hold_o, fif_o;
  logic [1:0] fidex_o, fexm_o, wa_o, wb_o;
  logic [1:0] fa_o [2];
  logic [1:0] fb_o [2];
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] sc_o [2];
  logic [31:0] fc_o [2];
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_unit #(
    .REG_ADDR_W   (5),
    .LOAD_STALLS  (1),
    .BRANCH_STAGE (3)
  ) u0 (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_dest      (id_dest),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .id_jump      (id_jump),
    .branch_taken (branch_taken),
    .pc_hold      (pc_hold_o[0]),
    .if_id_hold   (if_id_hold_o[0]),
    .flush_if_id  (fif_o[0]),
    .flush_id_ex  (fidex_o[0]),
    .flush_ex_mem (fexm_o[0]),
    .fwd_a        (fa_o[0]),
    .fwd_b        (fb_o[0]),
    .wb_bypass_a  (wa_o[0]),
    .wb_bypass_b  (wb_o[0])
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_count  (sc_o[0]),
    .flush_count  (fc_o[0])
`endif
  );

  pipeline_hazard_unit #(
    .REG_ADDR_W   (5),
    .LOAD_STALLS  (3),
    .BRANCH_STAGE (2)
  ) u1 (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_dest      (id_dest),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .id_jump      (id_jump),
    .branch_taken (branch_taken),
    .pc_hold      (pc_hold_o[1]),
    .if_id_hold   (if_id_hold_o[1]),
    .flush_if_id  (fif_o[1]),
    .flush_id_ex  (fidex_o[1]),
    .flush_ex_mem (fexm_o[1]),
    .fwd_a        (fa_o[1]),
    .fwd_b        (fb_o[1]),
    .wb_bypass_a  (wa_o[1]),
    .wb_bypass_b  (wb_o[1])
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_count  (sc_o[1]),
    .flush_count  (fc_o[1])
`endif
  );

  // reference model: instruction records per stage, stall as a
  // count of remaining bubble cycles
  typedef struct {
    bit       v;
    bit [4:0] dest;
    bit       rw;
    bit       mr;
  } ent_t;

  ent_t        m_ex [2];
  ent_t        m_mem [2];
  ent_t        m_wb [2];
  int          m_left [2];
  bit [1:0]    m_fa [2];
  bit [1:0]    m_fb [2];
  int unsigned m_sc [2];
  int unsigned m_fc [2];
  int          cfg_ls [2] = '{1, 3};
  int          cfg_bs [2] = '{3, 2};
  logic [10:0] last_out [2];

  function automatic bit wr(ent_t e, bit [4:0] r);
    return e.v && e.rw && (e.dest == r) && (r != 0);
  endfunction

  function automatic bit rd_rs();
    return id_valid && id_uses_rs;
  endfunction

  function automatic bit rd_rt();
    return id_valid && id_uses_rt;
  endfunction

  function automatic bit m_load_hit(int k);
    return (m_left[k] == 0) && m_ex[k].mr
      && ((rd_rs() && wr(m_ex[k], id_rs))
       || (rd_rt() && wr(m_ex[k], id_rt)));
  endfunction

  function automatic bit m_stall(int k);
    return (m_left[k] > 0 || m_load_hit(k))
      && !branch_taken;
  endfunction

  function automatic logic [10:0] model_out(int k);
    bit st, fif;
    st  = m_stall(k);
    fif = branch_taken || (id_jump && id_valid && !st);
    return {st, st, fif, branch_taken || st,
            branch_taken && (cfg_bs[k] == 3),
            m_fa[k], m_fb[k],
            rd_rs() && wr(m_wb[k], id_rs),
            rd_rt() && wr(m_wb[k], id_rt)};
  endfunction

  function automatic logic [10:0] dut_out(int k);
    return {pc_hold_o[k], if_id_hold_o[k], fif_o[k],
            fidex_o[k], fexm_o[k], fa_o[k], fb_o[k],
            wa_o[k], wb_o[k]};
  endfunction

  function automatic void model_reset(int k);
    ent_t z;
    z = '{v: 0, dest: 0, rw: 0, mr: 0};
    m_ex[k]   = z;
    m_mem[k]  = z;
    m_wb[k]   = z;
    m_left[k] = 0;
    m_fa[k]   = 0;
    m_fb[k]   = 0;
    m_sc[k]   = 0;
    m_fc[k]   = 0;
  endfunction

  function automatic void model_clock(int k);
    bit   st, lh, fif;
    ent_t ide, z;
    st  = m_stall(k);
    lh  = m_load_hit(k);
    fif = branch_taken || (id_jump && id_valid && !st);
    z   = '{v: 0, dest: 0, rw: 0, mr: 0};
    ide = '{v: id_valid && !st && !branch_taken,
            dest: id_dest, rw: id_reg_write,
            mr: id_mem_read};
    if (branch_taken) begin
      m_fa[k] = 0;
      m_fb[k] = 0;
    end else if (!st) begin
      m_fa[k] = (rd_rs() && wr(m_ex[k], id_rs)) ? 2
              : (rd_rs() && wr(m_mem[k], id_rs)) ? 1 : 0;
      m_fb[k] = (rd_rt() && wr(m_ex[k], id_rt)) ? 2
              : (rd_rt() && wr(m_mem[k], id_rt)) ? 1 : 0;
    end
    if (branch_taken) m_left[k] = 0;
    else if (m_left[k] > 0) m_left[k] = m_left[k] - 1;
    else if (lh) m_left[k] = cfg_ls[k] - 1;
    if (st && m_sc[k] != 32'hFFFF_FFFF) m_sc[k]++;
    if (fif && m_fc[k] != 32'hFFFF_FFFF) m_fc[k]++;
    m_wb[k]  = m_mem[k];
    m_mem[k] = (branch_taken && cfg_bs[k] == 3)
             ? z : m_ex[k];
    m_ex[k]  = ide;
  endfunction

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic cycle(string tag, bit use_exp,
                       logic [10:0] exp);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      last_out[k] = dut_out(k);
      chk($sformatf("%s u%0d", tag, k),
          32'(dut_out(k)), 32'(model_out(k)));
`ifdef HAZ_PERF_CNT_EN
      chk($sformatf("%s stall_count u%0d", tag, k),
          sc_o[k], m_sc[k]);
      chk($sformatf("%s flush_count u%0d", tag, k),
          fc_o[k], m_fc[k]);
`endif
    end
    if (use_exp)
      chk($sformatf("%s table", tag),
          32'(dut_out(0)), 32'(exp));
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!reset) model_reset(k);
      else model_clock(k);
    end
    #1;
  endtask

  typedef struct {
    bit          v;
    bit [4:0]    rs, rt;
    bit          urs, urt;
    bit [4:0]    dest;
    bit          rw, mr, jmp, br;
    logic [10:0] exp;
  } vec_t;

  vec_t tbl [$];

  function automatic logic [10:0] E(
    int h, int fif, int fidex, int fexm,
    int fa, int fb, int wa, int wb);
    return {h[0], h[0], fif[0], fidex[0], fexm[0],
            fa[1:0], fb[1:0], wa[0], wb[0]};
  endfunction

  function automatic vec_t V(
    int v, int rs, int rt, int urs, int urt, int dest,
    int rw, int mr, int jmp, int br, logic [10:0] exp);
    vec_t t;
    t.v    = v[0];
    t.rs   = rs[4:0];
    t.rt   = rt[4:0];
    t.urs  = urs[0];
    t.urt  = urt[0];
    t.dest = dest[4:0];
    t.rw   = rw[0];
    t.mr   = mr[0];
    t.jmp  = jmp[0];
    t.br   = br[0];
    t.exp  = exp;
    return t;
  endfunction

  task automatic drive(vec_t t);
    id_valid     = t.v;
    id_rs        = t.rs;
    id_rt        = t.rt;
    id_uses_rs   = t.urs;
    id_uses_rt   = t.urt;
    id_dest      = t.dest;
    id_reg_write = t.rw;
    id_mem_read  = t.mr;
    id_jump      = t.jmp;
    branch_taken = t.br;
  endtask

  initial begin
    vec_t idle, lw3, add3;
    int   h0, h1;
    logic [10:0] zero11;
    zero11 = '0;
    idle = V(0,0,0,0,0,0,0,0,0,0, E(0,0,0,0,0,0,0,0));
    lw3  = V(1,0,0,1,0,3,1,1,0,0, E(0,0,0,0,0,0,0,0));
    add3 = V(1,3,3,1,1,4,1,0,0,0, E(0,0,0,0,0,0,0,0));

    // add->sub fwd 10, with NOP fwd 01
    tbl.push_back(idle);
    tbl.push_back(V(1,1,2,1,1,3,1,0,0,0, E(0,0,0,0,0,0,0,0)));
    tbl.push_back(V(1,3,5,1,1,4,1,0,0,0, E(0,0,0,0,0,0,0,0)));
    tbl.push_back(V(0,0,0,0,0,0,0,0,0,0, E(0,0,0,0,2,0,0,0)));
    tbl.push_back(V(1,1,2,1,1,3,1,0,0,0, E(0,0,0,0,0,0,0,0)));
    tbl.push_back(idle);
    tbl.push_back(V(1,3,5,1,1,4,1,0,0,0, E(0,0,0,0,0,0,0,0)));
    tbl.push_back(V(0,0,0,0,0,0,0,0,0,0, E(0,0,0,0,1,0,0,0)));
    // load-use: one hold, then 01/01
    tbl.push_back(lw3);
    tbl.push_back(V(1,3,3,1,1,4,1,0,0,0, E(1,0,1,0,0,0,0,0)));
    tbl.push_back(add3);
    tbl.push_back(V(0,0,0,0,0,0,0,0,0,0, E(0,0,0,0,1,1,0,0)));
    // writes to $0 never forward
    tbl.push_back(V(1,0,0,1,0,0,1,0,0,0, E(0,0,0,0,0,0,0,0)));
    tbl.push_back(V(1,0,0,1,1,4,1,0,0,0, E(0,0,0,0,0,0,0,0)));
    tbl.push_back(idle);
    // beq in MEM flushes younger $7 writer
    tbl.push_back(V(1,1,2,1,1,0,0,0,0,0, E(0,0,0,0,0,0,0,0)));
    tbl.push_back(V(1,1,0,1,0,7,1,0,0,0, E(0,0,0,0,0,0,0,0)));
    tbl.push_back(V(1,1,2,1,1,9,1,0,0,1, E(0,1,1,1,0,0,0,0)));
    tbl.push_back(V(1,7,7,1,1,10,1,0,0,0, E(0,0,0,0,0,0,0,0)));
    tbl.push_back(idle);
    // load-use with branch: branch wins
    tbl.push_back(lw3);
    tbl.push_back(V(1,3,3,1,1,4,1,0,0,1, E(0,1,1,1,0,0,0,0)));
    tbl.push_back(idle);
    // jump, then jump blocked by stall
    tbl.push_back(V(1,0,0,0,0,0,0,0,1,0, E(0,1,0,0,0,0,0,0)));
    tbl.push_back(idle);
    tbl.push_back(V(1,0,0,1,0,5,1,1,0,0, E(0,0,0,0,0,0,0,0)));
    tbl.push_back(V(1,5,0,1,0,0,0,0,1,0, E(1,0,1,0,0,0,0,0)));
    tbl.push_back(V(1,5,0,1,0,0,0,0,1,0, E(0,1,0,0,0,0,0,0)));
    tbl.push_back(V(0,0,0,0,0,0,0,0,0,0, E(0,0,0,0,1,0,0,0)));
    // WB bypass three slots later
    tbl.push_back(V(1,1,0,1,0,8,1,0,0,0, E(0,0,0,0,0,0,0,0)));
    tbl.push_back(idle);
    tbl.push_back(idle);
    tbl.push_back(V(1,8,8,1,1,11,1,0,0,0, E(0,0,0,0,0,0,1,1)));
    tbl.push_back(idle);

    for (int k = 0; k < 2; k++) model_reset(k);
    reset = 1'b0;
    drive(idle);
    @(posedge clk);
    #1;
    cycle("reset", 1'b1, zero11);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      cycle($sformatf("vec%0d", i), 1'b1, tbl[i].exp);
    end

    // reset while the 3-deep instance is mid-stall
    drive(lw3);
    cycle("rs lw", 1'b0, zero11);
    drive(add3);
    cycle("rs detect", 1'b0, zero11);
    cycle("rs stall", 1'b0, zero11);
    chk("mid stall u1 hold", 32'(last_out[1][10]), 32'd1);
    reset = 1'b0;
    cycle("rs assert", 1'b0, zero11);
    reset = 1'b1;
    cycle("rs after", 1'b0, zero11);
    chk("after reset u0", 32'(last_out[0]), 32'd0);
    chk("after reset u1", 32'(last_out[1]), 32'd0);
`ifdef HAZ_PERF_CNT_EN
    chk("stall_count cleared", sc_o[1], 32'd0);
`endif

    // stall depth: 1 vs 3 hold cycles
    drive(lw3);
    cycle("depth lw", 1'b0, zero11);
    drive(add3);
    h0 = 0;
    h1 = 0;
    for (int i = 0; i < 5; i++) begin
      cycle("depth add", 1'b0, zero11);
      h0 += int'(last_out[0][10]);
      h1 += int'(last_out[1][10]);
    end
    chk("hold cycles ls1", 32'(h0), 32'd1);
    chk("hold cycles ls3", 32'(h1), 32'd3);
`ifdef HAZ_PERF_CNT_EN
    chk("stall_count ls3", sc_o[1], 32'd3);
`endif

    for (int i = 0; i < 800; i++) begin
      reset        = ($urandom_range(0, 63) != 0);
      id_valid     = ($urandom_range(0, 4) != 0);
      id_rs        = 5'($urandom_range(0, 7));
      id_rt        = 5'($urandom_range(0, 7));
      id_uses_rs   = 1'($urandom);
      id_uses_rt   = 1'($urandom);
      id_dest      = 5'($urandom_range(0, 7));
      id_reg_write = ($urandom_range(0, 3) != 0);
      id_mem_read  = ($urandom_range(0, 2) == 0);
      id_jump      = ($urandom_range(0, 7) == 0);
      branch_taken = ($urandom_range(0, 9) == 0);
      cycle("rand", 1'b0, zero11);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
